// File: rtl/gbt_rx_phalgnr_pkg.sv
// Shared types and constants for the RX frame-clock phase-aligner DPS logic.
package gbt_rx_phalgnr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_DONE
    } dps_state_t;

    // 720 MHz VCO, 8 taps per VCO period, outclk divided by 18
    localparam int STEPS_PER_PERIOD_DEF = 144;

    localparam logic [4:0] CNTSEL_C0  = 5'd0;
    localparam logic [4:0] CNTSEL_C1  = 5'd1;
    localparam logic [4:0] CNTSEL_C2  = 5'd2;
    localparam logic [4:0] CNTSEL_C3  = 5'd3;
    localparam logic [4:0] CNTSEL_ALL = 5'd31;

endpackage

// File: rtl/gbt_rx_phalgnr_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module gbt_rx_phalgnr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// DPS initiator: steps the PLL output phase one tap at a time via the
// phase_en/updn/phase_done handshake and tracks position modulo one period.
module gbt_rx_frameclk_phalgnr_dps_ctrl
    import gbt_rx_phalgnr_pkg::*;
#(
    parameter logic [4:0] CNTSEL           = CNTSEL_C0,
    parameter int         STEP_W           = 8,
    parameter int         STEPS_PER_PERIOD = STEPS_PER_PERIOD_DEF,
    parameter int         POS_W            = 8,
    parameter int         PHASE_EN_CYCLES  = 2,
    parameter int         TIMEOUT_CYCLES   = 1024
) (
    input  logic              scanclk,
    input  logic              rst,
    input  logic              locked,
    input  logic              phase_done,
    input  logic              start,
    input  logic              dir,
    input  logic [STEP_W-1:0] num_steps,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    output logic [POS_W-1:0]  position
);

    localparam int PW = (PHASE_EN_CYCLES > 1) ? $clog2(PHASE_EN_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0]    PCNT_LAST = PW'(PHASE_EN_CYCLES - 1);
    localparam logic [TW-1:0]    TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(STEPS_PER_PERIOD - 1);

    dps_state_t        state;
    logic              locked_s;
    logic              phase_done_s;
    logic              phase_en_q;
    logic [STEP_W-1:0] remaining;
    logic [PW-1:0]     pcnt;
    logic [TW-1:0]     tcnt;
    logic [POS_W-1:0]  next_pos;

    gbt_rx_phalgnr_sync2 u_sync_locked (
        .clk (scanclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    gbt_rx_phalgnr_sync2 u_sync_done (
        .clk (scanclk),
        .rst (rst),
        .d   (phase_done),
        .q   (phase_done_s)
    );

    always_comb begin
        next_pos = position;
        if (updn)
            next_pos = (position == POS_LAST) ? '0 : position + POS_W'(1);
        else
            next_pos = (position == '0) ? POS_LAST : position - POS_W'(1);
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase_en_q <= 1'b0;
            updn       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            position   <= '0;
            remaining  <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && !locked_s) begin
                error      <= 1'b1;
                phase_en_q <= 1'b0;
                state      <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && locked_s) begin
                            updn      <= dir;
                            remaining <= num_steps;
                            error     <= 1'b0;
                            pcnt      <= '0;
                            if (num_steps == '0) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                phase_en_q <= 1'b1;
                                state      <= ST_PULSE;
                            end
                        end
                    end
                    ST_PULSE: begin
                        if (pcnt == PCNT_LAST) begin
                            phase_en_q <= 1'b0;
                            tcnt       <= '0;
                            state      <= ST_WAIT_LOW;
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                    ST_WAIT_LOW: begin
                        tcnt <= tcnt + TW'(1);
                        if (!phase_done_s) begin
                            state <= ST_WAIT_HIGH;
                        end else if (tcnt == TCNT_LAST) begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        tcnt <= tcnt + TW'(1);
                        if (phase_done_s) begin
                            position  <= next_pos;
                            remaining <= remaining - STEP_W'(1);
                            pcnt      <= '0;
                            if (remaining == STEP_W'(1)) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                phase_en_q <= 1'b1;
                                state      <= ST_PULSE;
                            end
                        end else if (tcnt == TCNT_LAST) begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // rst gates phase_en combinationally so the PLL sees the step abort at once
    assign phase_en = phase_en_q & ~rst;
    assign ready    = (state == ST_IDLE) && locked_s;
    assign busy     = (state != ST_IDLE);
    assign cntsel   = CNTSEL;

endmodule

// File: doc/gbt_rx_frameclk_phalgnr_dps_ctrl.md
# gbt_rx_frameclk_phalgnr_dps_ctrl

Dynamic-phase-shift (DPS) initiator for the Stratix V RX frame-clock phase-aligner PLL: accepts "shift N steps up/down" requests and drives the PLL's `phase_en`/`updn`/`cntsel` handshake, one step at a time, until `phase_done` confirms each step. It sits between the GBT RX frame-clock phase-alignment logic and the PLL wrapper, in the `scanclk` domain. It tracks the accumulated phase position of the 40 MHz output modulo one output period, and flags timeout or loss of lock.

## Interface
- `CNTSEL`, 5'd0: counter select driven on `cntsel` (C0 = outclk_0).
- `STEP_W`, 8: width of `num_steps`.
- `STEPS_PER_PERIOD`, 144: phase steps per outclk period (720 MHz VCO / 8 taps, divide 18).
- `POS_W`, 8: width of `position`; must hold `STEPS_PER_PERIOD-1`.
- `PHASE_EN_CYCLES`, 2: `phase_en` high time per step, in scanclk cycles (≥1).
- `TIMEOUT_CYCLES`, 1024: max scanclk cycles waiting for `phase_done` per step.

Ports:
- `scanclk` in 1: sole clock (DPS scan clock).
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock, asynchronous; 2-FF synchronised internally.
- `phase_done` in 1: PLL step-done, asynchronous; 2-FF synchronised internally.
- `start` in 1: request strobe, accepted only when `ready`=1.
- `dir` in 1: 1 = shift up (later), 0 = down; sampled with `start`.
- `num_steps` in STEP_W: step count; sampled with `start`.
- `ready` out 1: IDLE and synced `locked`=1.
- `busy` out 1: request in progress.
- `done` out 1: one-cycle pulse, request completed normally.
- `error` out 1: sticky; set on timeout or lock loss, cleared by next accepted `start` or `rst`.
- `phase_en` out 1, `updn` out 1, `cntsel` out 5: to PLL DPS port.
- `position` out POS_W: accumulated phase step position, 0..STEPS_PER_PERIOD-1.

## Operation
- FSM states: IDLE, PULSE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE: `start`&`ready` → latch `dir` into `updn`, latch `num_steps` into `remaining`, clear `error`. If `num_steps`=0 → DONE, otherwise → PULSE. A `start` outside IDLE, or while synced `locked`=0, is ignored; no error is raised.
- PULSE: `phase_en`=1 for exactly PHASE_EN_CYCLES cycles, then → WAIT_LOW.
- WAIT_LOW: wait for synced `phase_done`=0, then → WAIT_HIGH.
- WAIT_HIGH: wait for synced `phase_done`=1. Then update `position`, decrement `remaining`. If `remaining` is now 0 → DONE, otherwise → PULSE.
- DONE: `done`=1 for one cycle → IDLE.
- Timeout: a counter clears on PULSE exit and counts during WAIT_LOW+WAIT_HIGH. Reaching TIMEOUT_CYCLES → `error`=1, → IDLE; `position` is not updated for the failed step.
- Lock loss: synced `locked`=0 in any non-IDLE state → `error`=1, `phase_en`=0 on the next cycle, → IDLE. `done` is not pulsed.
- Position wrap: up with `position`=STEPS_PER_PERIOD-1 → 0; down with `position`=0 → STEPS_PER_PERIOD-1.
- `cntsel` is constant CNTSEL. `updn` holds its value through the whole request.

## Timing
- Reset values: `phase_en`=0, `updn`=0, `cntsel`=CNTSEL, `busy`=0, `done`=0, `error`=0, `position`=0, `ready`=0 until synced `locked`=1, FSM in IDLE, sync flops 0.
- `start` accepted at edge k → `busy`=1 and `phase_en`=1 from k+1 through k+PHASE_EN_CYCLES.
- Sync latency is 2 cycles: a `phase_done` rise at the pins is seen at WAIT_HIGH exit after ≥2 cycles. `done` is asserted the cycle after the final WAIT_HIGH exit; `ready` returns the cycle after that.
- `num_steps`=0: `done` at k+1, with no `phase_en` activity.
- Per-step minimum: PHASE_EN_CYCLES + 2 cycles + PLL response time.
- `position` updates on the same edge as WAIT_HIGH exit.
- `rst` mid-request: all outputs go to reset values on the next edge, and `phase_en` drops immediately.

## Structure
- Shared package `gbt_rx_phalgnr_pkg`: FSM state enum, STEPS_PER_PERIOD default, DPS `cntsel` encodings.
- Sub-module `gbt_rx_phalgnr_sync2`: 2-FF synchroniser with synchronous reset, instantiated for `locked` and `phase_done`.

## Test plan
- Reset, lock high, `start` with `dir`=1 and `num_steps`=3, PLL model replying `phase_done` low/high 5 cycles after each pulse → three 2-cycle `phase_en` pulses, `updn`=1, single `done`, `position`=3, `error`=0.
- `position`=0, `dir`=0, `num_steps`=1 → `position`=143. Then `dir`=1, `num_steps`=1 → `position`=0.
- `num_steps`=0 → `done` at k+1, `phase_en` never high, `position` unchanged.
- PLL model never drops `phase_done` → `error`=1 after 1024 wait cycles, FSM in IDLE, no `done`, `position` unchanged. The next `start` clears `error`.
- `locked` dropped during step 2 of 5 → `error`=1 within 3 cycles, `phase_en`=0, `position`=1, `ready`=0 until relock.
- `start` pulsed while `busy`, and `rst` asserted mid-step → extra `start` ignored (step count unchanged). After `rst`, all outputs are at reset values on the next edge.
